// File: rtl/ps2_rx_fifo_pkg.sv
// Shared types and constants for the PS/2 receiver with scan-code FIFO.
package ps2_rx_fifo_pkg;

  localparam int unsigned PS2_DATA_W     = 8;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Odd parity over data plus parity bit: a correct frame reduces to 1.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_fifo.sv
// First-word-fall-through FIFO with registered head, valid and level outputs.
module ps2_rx_fifo_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     push_ok_c,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [LW-1:0]    level_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             pop_c;
  logic             wr_c;

  assign pop_c     = pop & rd_valid;
  assign push_ok_c = (level != LW'(DEPTH)) | pop_c;
  assign wr_c      = push & push_ok_c;

  // Next head: a write into the slot that becomes the head bypasses the array.
  always_comb begin
    rd_ptr_nxt = pop_c ? AW'(rd_ptr + 1'b1) : rd_ptr;
    level_nxt  = LW'(level + LW'(wr_c) - LW'(pop_c));
    head_nxt   = mem[rd_ptr_nxt];
    if (wr_c && (rd_ptr_nxt == wr_ptr)) begin
      head_nxt = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_c) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_c) begin
        wr_ptr <= AW'(wr_ptr + 1'b1);
      end
      rd_ptr   <= rd_ptr_nxt;
      level    <= level_nxt;
      rd_valid <= (level_nxt != '0);
      if (level_nxt != '0) begin
        rd_data <= head_nxt;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronisers, frame FSM, checks, sticky flags, FWFT FIFO.
// Optional mid-frame abort on ps2_clk silence is enabled by defining PS2_TIMEOUT_EN.
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        rd_ready,
  input  logic                        clr_err,
  output logic                        rd_valid,
  output logic [PS2_DATA_W-1:0]       rd_data,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic [CNT_W-1:0]            frame_cnt
);

  logic [SYNC_STAGES-1:0] sync_clk;
  logic [SYNC_STAGES-1:0] sync_data;
  logic                   fall_c;
  logic                   bit_c;

  ps2_state_e             state;
  ps2_state_e             state_nxt;
  logic [2:0]             bit_idx;
  logic [2:0]             bit_idx_nxt;
  logic [PS2_DATA_W-1:0]  shreg;
  logic [PS2_DATA_W-1:0]  shreg_nxt;
  logic                   par_bit;
  logic                   par_bit_nxt;
  logic                   done_c;
  logic                   par_ok_c;
  logic                   good_c;
  logic                   push_ok_c;
  logic                   timeout_c;

  // Reset to all ones so an idle-high line produces no false falling edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_clk  <= '1;
      sync_data <= '1;
    end else begin
      sync_clk  <= {sync_clk[SYNC_STAGES-2:0], ps2_clk};
      sync_data <= {sync_data[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign fall_c = sync_clk[SYNC_STAGES-1] & ~sync_clk[SYNC_STAGES-2];
  assign bit_c  = sync_data[SYNC_STAGES-2];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_bit_nxt;
    end
  end

  // Frame sequencing; every step is taken on a synchronised ps2_clk fall.
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    par_bit_nxt = par_bit;
    done_c      = 1'b0;
    if (timeout_c) begin
      state_nxt = ST_IDLE;
    end else if (fall_c) begin
      unique case (state)
        ST_IDLE: begin
          if (!bit_c) begin
            state_nxt   = ST_DATA;
            bit_idx_nxt = '0;
          end
        end
        ST_DATA: begin
          shreg_nxt   = {bit_c, shreg[PS2_DATA_W-1:1]};
          bit_idx_nxt = 3'(bit_idx + 3'd1);
          if (bit_idx == 3'(PS2_DATA_W - 1)) begin
            state_nxt = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_bit_nxt = bit_c;
          state_nxt   = ST_STOP;
        end
        ST_STOP: begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign par_ok_c = odd_parity_ok(shreg, par_bit);
  assign good_c   = done_c & bit_c & par_ok_c;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tmo_cnt <= '0;
    end else if ((state == ST_IDLE) || fall_c || timeout_c) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= TMO_W'(tmo_cnt + 1'b1);
    end
  end

  assign timeout_c = (state != ST_IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign timeout_c  = 1'b0;
`endif

  // Sticky flags: a same-cycle set overrides clr_err.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (clr_err) begin
        overflow   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (good_c && !push_ok_c) begin
        overflow <= 1'b1;
      end
      if (done_c && !par_ok_c) begin
        parity_err <= 1'b1;
      end
      if ((done_c && !bit_c) || timeout_c) begin
        frame_err <= 1'b1;
      end
      if (good_c && push_ok_c) begin
        frame_cnt <= CNT_W'(frame_cnt + 1'b1);
      end
    end
  end

  ps2_rx_fifo_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (good_c),
    .wdata     (shreg),
    .pop       (rd_ready),
    .push_ok_c (push_ok_c),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .level     (level)
  );

endmodule
